// File: rtl/mouse_bus_interface.sv
`default_nettype none
// ============================================================================
// Module  : mouse_bus_interface
// Brief   : Bus-mapped PS/2 mouse packet registers with interrupt, 1-deep queue
// Revision: 1.0 - initial release
// ============================================================================
module mouse_bus_interface #(
    parameter logic [7:0] BASE_ADDR = 8'hA0
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    input  logic [7:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_DX,
    input  logic [7:0] MOUSE_DY,
    input  logic       MOUSE_VALID
);

    localparam logic [1:0] c_OFS_CTRL = 2'd3;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_RAISED = 2'd1,
        S_QUEUED = 2'd2,
        S_RELOAD = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_status, r_dx, r_dy;
    logic [7:0] r_q_status, r_q_dx, r_q_dy;
    logic [3:0] r_overrun;
    logic       r_enable;
    logic [7:0] r_rd_data;
    logic       r_rd_oe;

    logic       w_valid;
    logic       w_load_vis;
    logic       w_load_vis_from_q;
    logic       w_load_q;
    logic       w_ovf_inc;
    logic [7:0] w_offset;
    logic       w_in_range;
    logic       w_ctrl_wr;
    logic [7:0] w_rd_mux;
    logic       w_unused_wdata;

    assign w_valid    = MOUSE_VALID & r_enable;
    assign w_offset   = BUS_ADDR - BASE_ADDR;
    assign w_in_range = (w_offset < 8'd4);
    assign w_ctrl_wr  = BUS_WE & w_in_range & (w_offset[1:0] == c_OFS_CTRL);
    assign w_unused_wdata = &{1'b0, BUS_DATA[6:1]};

    assign BUS_INTERRUPT_RAISE = (r_state == S_RAISED) || (r_state == S_QUEUED);
    assign BUS_DATA = r_rd_oe ? r_rd_data : 8'hzz;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_load_vis        = 1'b0;
        w_load_vis_from_q = 1'b0;
        w_load_q          = 1'b0;
        w_ovf_inc         = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_valid) begin
                    w_load_vis  = 1'b1;
                    w_state_nxt = S_RAISED;
                end
            end
            S_RAISED: begin
                if (w_valid) begin
                    w_load_q    = 1'b1;
                    w_state_nxt = BUS_INTERRUPT_ACK ? S_RELOAD : S_QUEUED;
                end else if (BUS_INTERRUPT_ACK) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_QUEUED: begin
                w_ovf_inc = w_valid;
                if (BUS_INTERRUPT_ACK) begin
                    w_state_nxt = S_RELOAD;
                end
            end
            S_RELOAD: begin
                // The queue empties into the visible registers this cycle, so a
                // packet arriving now can take the queue slot.
                w_load_vis_from_q = 1'b1;
                if (w_valid) begin
                    w_load_q    = 1'b1;
                    w_state_nxt = S_QUEUED;
                end else begin
                    w_state_nxt = S_RAISED;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_status   <= 8'h00;
            r_dx       <= 8'h00;
            r_dy       <= 8'h00;
            r_q_status <= 8'h00;
            r_q_dx     <= 8'h00;
            r_q_dy     <= 8'h00;
        end else begin
            if (w_load_vis) begin
                r_status <= MOUSE_STATUS;
                r_dx     <= MOUSE_DX;
                r_dy     <= MOUSE_DY;
            end else if (w_load_vis_from_q) begin
                r_status <= r_q_status;
                r_dx     <= r_q_dx;
                r_dy     <= r_q_dy;
            end
            if (w_load_q) begin
                r_q_status <= MOUSE_STATUS;
                r_q_dx     <= MOUSE_DX;
                r_q_dy     <= MOUSE_DY;
            end
        end
    end

    // A clear request wins over a same-cycle overrun increment.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_enable  <= 1'b1;
            r_overrun <= 4'h0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= BUS_DATA[0];
            end
            if (w_ctrl_wr && BUS_DATA[7]) begin
                r_overrun <= 4'h0;
            end else if (w_ovf_inc && (r_overrun != 4'hF)) begin
                r_overrun <= r_overrun + 4'h1;
            end
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_offset[1:0])
            2'd0:    w_rd_mux = r_status;
            2'd1:    w_rd_mux = r_dx;
            2'd2:    w_rd_mux = r_dy;
            default: w_rd_mux = {r_overrun, 1'b0, (r_state == S_QUEUED),
                                 (r_state != S_EMPTY), r_enable};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_data <= 8'h00;
            r_rd_oe   <= 1'b0;
        end else begin
            r_rd_data <= w_rd_mux;
            r_rd_oe   <= w_in_range & ~BUS_WE;
        end
    end

endmodule
`default_nettype wire
